// File: rtl/fp4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp4_pkg
// Description : Shared FP4 (E2M1) / FP8 (E4M3) field constants and the
//               unpacker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fp4_pkg;

    // FP4 E2M1 field widths
    localparam int FP4_EXP_W = 2;
    localparam int FP4_MAN_W = 1;
    localparam int FP4_W     = 1 + FP4_EXP_W + FP4_MAN_W;

    // Exponent biases and the offset that re-biases an FP4 exponent to E4M3
    localparam int FP4_BIAS   = 1;
    localparam int FP8_BIAS   = 7;
    localparam int EXP_OFFSET = FP8_BIAS - FP4_BIAS;

    // Unpacker state encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fp4_to_fp8.sv
`default_nettype none
// ============================================================================
// Module      : fp4_to_fp8
// Description : Combinational expansion of one FP4 E2M1 code to FP8 E4M3.
//               The FP4 subnormal (e=0, m=1 = 0.5) becomes a normal E4M3
//               value; every FP4 value is exactly representable.
// Revision    : 1.0 - initial release
// ============================================================================
module fp4_to_fp8
    import fp4_pkg::*;
(
    input  logic [FP4_W-1:0] code,
    output logic [7:0]       fp8
);

    logic                 w_sign;
    logic [FP4_EXP_W-1:0] w_exp;
    logic [FP4_MAN_W-1:0] w_man;

    assign w_sign = code[FP4_W-1];
    assign w_exp  = code[FP4_W-2 -: FP4_EXP_W];
    assign w_man  = code[FP4_MAN_W-1:0];

    // Re-bias the exponent; zero and the FP4 subnormal are special cases
    always_comb begin
        fp8 = {w_sign, 7'b000_0000};
        if (w_exp == '0) begin
            if (w_man != '0) begin
                fp8 = {w_sign, 4'(EXP_OFFSET), 3'b000};
            end
        end else begin
            fp8 = {w_sign, 4'(w_exp) + 4'(EXP_OFFSET), w_man, 2'b00};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp4_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fp4_unpack
// Description : Accepts a word of packed FP4 E2M1 codes and emits them one per
//               handshake, nibble 0 first, each expanded to FP8 E4M3.
//               Optional macro FP4_UNPACK_ZCNT_EN adds a saturating counter
//               of emitted zero codes on the zero_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module fp4_unpack
    import fp4_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int ZCNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*NIBBLES-1:0]       in_word,
    input  logic [$clog2(NIBBLES)-1:0] in_len,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [7:0]                 out_data,
    output logic                       out_last
`ifdef FP4_UNPACK_ZCNT_EN
    ,
    output logic [ZCNT_W-1:0]          zero_cnt
`endif
);

    localparam int IDX_W = $clog2(NIBBLES);

    state_t               r_state;
    logic [4*NIBBLES-1:0] r_word;
    logic [IDX_W-1:0]     r_len;
    logic [IDX_W-1:0]     r_idx;
    logic [7:0]           r_out_data;
    logic                 r_out_last;

    logic                 w_accept;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [IDX_W-1:0]     w_sel_idx;
    logic [4*NIBBLES-1:0] w_src_word;
    logic [FP4_W-1:0]     w_nib [NIBBLES];
    logic [FP4_W-1:0]     w_code;
    logic [7:0]           w_dec;

    // A new word is taken in IDLE, or in EMIT as the last nibble leaves
    assign in_ready  = !reset && ((r_state == ST_IDLE) ||
                                  (out_ready && r_out_last));
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_EMIT);
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // The decoder looks one nibble ahead so its result can be registered:
    // nibble 0 of the incoming word on accept, otherwise nibble idx+1
    assign w_idx_nxt  = r_idx + IDX_W'(1);
    assign w_sel_idx  = w_accept ? '0 : w_idx_nxt;
    assign w_src_word = w_accept ? in_word : r_word;

    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
        assign w_nib[gi] = w_src_word[4*gi +: 4];
    end

    assign w_code = w_nib[w_sel_idx];

    fp4_to_fp8 u_dec (
        .code (w_code),
        .fp8  (w_dec)
    );

    // Control FSM: load a word, step through its nibbles, chain or go idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_word     <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_out_data <= 8'h00;
            r_out_last <= 1'b0;
        end else if (w_accept) begin
            r_state    <= ST_EMIT;
            r_word     <= in_word;
            r_len      <= in_len;
            r_idx      <= '0;
            r_out_data <= w_dec;
            r_out_last <= (in_len == '0);
        end else if ((r_state == ST_EMIT) && out_ready) begin
            if (!r_out_last) begin
                r_idx      <= w_idx_nxt;
                r_out_data <= w_dec;
                r_out_last <= (w_idx_nxt == r_len);
            end else begin
                r_state    <= ST_IDLE;
                r_out_last <= 1'b0;
            end
        end
    end

`ifdef FP4_UNPACK_ZCNT_EN
    logic [ZCNT_W-1:0] r_zero_cnt;
    logic              w_zero_hs;

    // Only a zero code expands to an all-zero magnitude, so test the output
    assign w_zero_hs = out_valid && out_ready && (r_out_data[6:0] == 7'd0);
    assign zero_cnt  = r_zero_cnt;

    // Saturating count of zero codes handed downstream
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero_cnt <= '0;
        end else if (w_zero_hs && (r_zero_cnt != '1)) begin
            r_zero_cnt <= r_zero_cnt + ZCNT_W'(1);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp4_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp4_unpack
// Description : Directed self-checking bench for fp4_unpack. Zero-counter
//               checks are built when FP4_UNPACK_ZCNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp4_unpack;

    localparam int NIBBLES = 4;
`ifdef FP4_UNPACK_ZCNT_EN
    localparam int ZCNT_W = 2;
`else
    localparam int ZCNT_W = 8;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*NIBBLES-1:0] in_word;
    logic [1:0]           in_len;
    logic                 out_valid;
    logic                 out_ready;
    logic [7:0]           out_data;
    logic                 out_last;
`ifdef FP4_UNPACK_ZCNT_EN
    logic [ZCNT_W-1:0]    zero_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp4_unpack #(
        .NIBBLES (NIBBLES),
        .ZCNT_W  (ZCNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef FP4_UNPACK_ZCNT_EN
        ,
        .zero_cnt  (zero_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check valid/data/last together for one emitted nibble
    task automatic chk_out(input string tag, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        chk({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        in_len    = '0;
        out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data",  {24'd0, out_data},  32'h00);
        chk("rst_last",  {31'd0, out_last},  32'd0);
        chk("rst_ready", {31'd0, in_ready},  32'd0);
`ifdef FP4_UNPACK_ZCNT_EN
        chk("rst_zcnt",  {30'd0, zero_cnt},  32'd0);
`endif
        reset = 1'b0;
        #1;
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        // Basic word, out_ready held high
        in_word = 16'h7321; in_len = 2'd3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk_out("w1_n0", 8'h30, 1'b0);
        chk("w1_n0_inrdy", {31'd0, in_ready}, 32'd0);
        tick(); chk_out("w1_n1", 8'h38, 1'b0);
        tick(); chk_out("w1_n2", 8'h3C, 1'b0);
        tick(); chk_out("w1_n3", 8'h4C, 1'b1);
        chk("w1_n3_inrdy", {31'd0, in_ready}, 32'd1);
        tick();
        chk("w1_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("w1_idle_ready", {31'd0, in_ready},  32'd1);

        // Backpressure on the first nibble for three cycles
        in_word = 16'h7321; in_len = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
        tick(); in_valid = 1'b0;
        chk_out("bp_h0", 8'h30, 1'b0);
        tick(); chk_out("bp_h1", 8'h30, 1'b0);
        tick(); chk_out("bp_h2", 8'h30, 1'b0);
        tick(); chk_out("bp_h3", 8'h30, 1'b0);
        out_ready = 1'b1;
        tick(); chk_out("bp_n1", 8'h38, 1'b0);
        tick(); chk_out("bp_n2", 8'h3C, 1'b0);
        tick(); chk_out("bp_n3", 8'h4C, 1'b1);
        tick(); chk("bp_idle", {31'd0, out_valid}, 32'd0);

        // Back-to-back words with no bubble
        in_word = 16'h7321; in_len = 2'd3; in_valid = 1'b1;
        tick();
        chk_out("bb_a0", 8'h30, 1'b0);
        in_word = 16'h1111;
        chk("bb_a0_inrdy", {31'd0, in_ready}, 32'd0);
        tick(); chk_out("bb_a1", 8'h38, 1'b0);
        tick(); chk_out("bb_a2", 8'h3C, 1'b0);
        tick(); chk_out("bb_a3", 8'h4C, 1'b1);
        chk("bb_a3_inrdy", {31'd0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0;
        chk_out("bb_b0", 8'h30, 1'b0);
        chk("bb_b0_inrdy", {31'd0, in_ready}, 32'd0);
        tick(); chk_out("bb_b1", 8'h30, 1'b0);
        tick(); chk_out("bb_b2", 8'h30, 1'b0);
        tick(); chk_out("bb_b3", 8'h30, 1'b1);
        tick(); chk("bb_idle", {31'd0, out_valid}, 32'd0);

        // Single-nibble word, negative zero
        in_word = 16'h0008; in_len = 2'd0; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk_out("one_n0", 8'h80, 1'b1);
        tick();
        chk("one_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("one_idle_ready", {31'd0, in_ready},  32'd1);

        // Reset mid-emission drops the rest of the word
        in_word = 16'h7321; in_len = 2'd3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk_out("mr_n0", 8'h30, 1'b0);
        tick(); chk_out("mr_n1", 8'h38, 1'b0);
        reset = 1'b1;
        tick();
        chk("mr_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_rst_ready", {31'd0, in_ready},  32'd0);
        reset = 1'b0;
        tick(); chk("mr_post_valid0", {31'd0, out_valid}, 32'd0);
        tick(); chk("mr_post_valid1", {31'd0, out_valid}, 32'd0);
        in_word = 16'h7321; in_len = 2'd3; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        chk_out("mr_re_n0", 8'h30, 1'b0);
        tick(); chk_out("mr_re_n1", 8'h38, 1'b0);
        tick(); chk_out("mr_re_n2", 8'h3C, 1'b0);
        tick(); chk_out("mr_re_n3", 8'h4C, 1'b1);
        tick(); chk("mr_re_idle", {31'd0, out_valid}, 32'd0);

`ifdef FP4_UNPACK_ZCNT_EN
        // Six all-zero words streamed back to back; the 2-bit count saturates
        reset = 1'b1;
        tick();
        reset = 1'b0;
        in_word = 16'h0808; in_len = 2'd3; in_valid = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            in_valid = (i < 20);
            chk_out($sformatf("zc_o%0d", i), (i % 2 == 0) ? 8'h80 : 8'h00, (i % 4 == 3));
            chk($sformatf("zc_c%0d", i), {30'd0, zero_cnt}, (i < 3) ? i : 3);
            tick();
        end
        chk("zc_idle", {31'd0, out_valid}, 32'd0);
        chk("zc_final", {30'd0, zero_cnt}, 32'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
